// File: rtl/sr_reg_bank.sv
// sr_reg_bank: WIDTH clocked SR cells (active-low s_n/r_n, gate en) with a selectable S=R=0 policy and conflict flagging. Ports: clk, rst (sync, active-high), en, s_n, r_n, clr_err -> q, q_n, err (sticky), err_bits, err_cnt. Defining SR_REG_CONFLICT_CNT_EN builds the saturating conflict counter; otherwise err_cnt is 0.
module sr_reg_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT = '0,
  parameter int BOTH_MODE = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s_n,
  input  logic [WIDTH-1:0] r_n,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             err,
  output logic [WIDTH-1:0] err_bits,
  output logic [CNT_W-1:0] err_cnt
);
  logic [WIDTH-1:0] set_m, rst_m, both_m, tog_m, flag_m, q_next;
  logic ev;
  always_comb begin
    set_m  = en ? (~s_n & r_n) : '0;
    rst_m  = en ? (s_n & ~r_n) : '0;
    both_m = en ? (~s_n & ~r_n) : '0;
    tog_m  = (BOTH_MODE != 0) ? both_m : '0;
    flag_m = (BOTH_MODE != 0) ? '0 : both_m;
    q_next = ((q | set_m) & ~rst_m) ^ tog_m;
    ev     = |flag_m;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= INIT;
      err      <= 1'b0;
      err_bits <= '0;
    end else begin
      q        <= q_next;
      err_bits <= flag_m;
      err      <= ev ? 1'b1 : (clr_err ? 1'b0 : err);
    end
  end
  assign q_n = ~q;
`ifdef SR_REG_CONFLICT_CNT_EN
  // A same-cycle clear and event yields a count of exactly one.
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (ev) err_cnt <= clr_err ? CNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + CNT_W'(1));
    else if (clr_err) err_cnt <= '0;
  end
`else
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank: directed checks of sr_reg_bank in hold/flag and toggle modes.
module tb_sr_reg_bank;
`ifdef SR_REG_CONFLICT_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, rst, en, clr_err;
  logic [3:0] s_n, r_n, q0, qn0, eb0, q1, qn1, eb1;
  logic err0, err1;
  logic [2:0] cnt0, cnt1;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sr_reg_bank #(.WIDTH(4), .INIT(4'b0000), .BOTH_MODE(0), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .en(en), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(q0), .q_n(qn0), .err(err0), .err_bits(eb0), .err_cnt(cnt0));
  sr_reg_bank #(.WIDTH(4), .INIT(4'b0000), .BOTH_MODE(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .en(en), .s_n(s_n), .r_n(r_n), .clr_err(clr_err),
    .q(q1), .q_n(qn1), .err(err1), .err_bits(eb1), .err_cnt(cnt1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic e, input logic [3:0] s, input logic [3:0] r, input logic c);
    en = e; s_n = s; r_n = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] ecnt(input int n);
    return CE ? 3'(n) : 3'd0;
  endfunction
  initial begin
    rst = 1'b1;
    tick(1, 4'b0000, 4'b1111, 1);
    tick(1, 4'b0000, 4'b1111, 1);
    chk("rst_q", q0, 4'b0000);
    chk("rst_qn", qn0, 4'b1111);
    chk("rst_err", err0, 0);
    chk("rst_eb", eb0, 0);
    chk("rst_cnt", cnt0, 0);
    rst = 1'b0;
    tick(1, 4'b1010, 4'b1111, 0);
    chk("set_q", q0, 4'b0101);
    chk("set_qn", qn0, 4'b1010);
    tick(1, 4'b1111, 4'b1011, 0);
    chk("reset_q", q0, 4'b0001);
    chk("reset_err", err0, 0);
    for (int i = 0; i < 3; i++) tick(0, 4'b0000, 4'b1111, 0);
    chk("gate_q", q0, 4'b0001);
    chk("gate_eb", eb0, 0);
    tick(1, 4'b0000, 4'b1111, 0);
    chk("ungate_q", q0, 4'b1111);
    tick(1, 4'b1100, 4'b0011, 0);
    chk("mix_q", q0, 4'b0011);
    tick(1, 4'b1011, 4'b0011, 0);
    chk("conf_q", q0, 4'b0011);
    chk("conf_eb", eb0, 4'b0100);
    chk("conf_err", err0, 1);
    chk("conf_cnt", cnt0, ecnt(1));
    chk("tog_q", q1, 4'b0111);
    chk("tog_eb", eb1, 0);
    chk("tog_err", err1, 0);
    for (int i = 0; i < 7; i++) tick(1, 4'b1011, 4'b0011, 0);
    chk("sat_cnt", cnt0, ecnt(7));
    tick(0, 4'b1111, 4'b1111, 0);
    chk("idle_eb", eb0, 0);
    chk("idle_err", err0, 1);
    chk("idle_cnt", cnt0, ecnt(7));
    tick(1, 4'b1111, 4'b1111, 1);
    chk("clr_err", err0, 0);
    chk("clr_cnt", cnt0, 0);
    tick(1, 4'b1010, 4'b0101, 0);
    chk("b1_setup", q1, 4'b0101);
    tick(1, 4'b0000, 4'b0000, 0);
    chk("b1_tog1", q1, 4'b1010);
    chk("b1_qn", qn1, 4'b0101);
    chk("b1_err", err1, 0);
    chk("b0_hold", q0, 4'b0101);
    chk("b0_eb", eb0, 4'b1111);
    tick(1, 4'b0000, 4'b0000, 0);
    chk("b1_tog2", q1, 4'b0101);
    chk("b0_cnt2", cnt0, ecnt(2));
    rst = 1'b1;
    tick(1, 4'b0000, 4'b1111, 0);
    chk("mid_rst_q", q0, 4'b0000);
    chk("mid_rst_err", err0, 0);
    chk("mid_rst_cnt", cnt0, 0);
    rst = 1'b0;
    tick(1, 4'b0000, 4'b0000, 1);
    chk("clr_ev_err", err0, 1);
    chk("clr_ev_cnt", cnt0, ecnt(1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
